// File: rtl/axi2mem_if.sv
// AXI_BUS: reduced AXI4 channel bundle (32-bit data) shared by the core-side master and axi2mem
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      aw_valid, aw_ready;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [1:0]                aw_burst;
  logic                      w_valid, w_ready, w_last;
  logic [31:0]               w_data;
  logic [3:0]                w_strb;
  logic                      b_valid, b_ready;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic                      ar_valid, ar_ready;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [1:0]                ar_burst;
  logic                      r_valid, r_ready, r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [31:0]               r_data;
  logic [1:0]                r_resp;
  modport Slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_burst, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, ar_burst, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
  modport Master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_burst, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, ar_burst, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi2mem.sv
// axi2mem: AXI4 slave to single-port request/grant memory bridge, one transaction at a time
module axi2mem #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  AXI_BUS.Slave                     slave,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [AXI_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ_REQ, READ_DATA} state_t;
  state_t                    state;
  logic                      prio_q, resp_err_q, r_full_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [7:0]                len_q;
  logic [1:0]                burst_q;
  logic [8:0]                cnt_q;
  logic [31:0]               r_buf_q;
  logic                      in_range, pick_w, pick_r, w_hs, r_hs;
  assign in_range  = cnt_q <= {1'b0, len_q};
  assign pick_w    = state == IDLE && !rst && slave.aw_valid && (!slave.ar_valid || !prio_q);
  assign pick_r    = state == IDLE && !rst && slave.ar_valid && (!slave.aw_valid || prio_q);
  assign w_hs      = slave.w_valid && slave.w_ready;
  assign r_hs      = slave.r_valid && slave.r_ready;
  assign next_addr = burst_q == 2'b00 ? addr_q : addr_q + AXI_ADDR_WIDTH'(4);
  assign slave.aw_ready = pick_w;
  assign slave.ar_ready = pick_r;
  // beats past len+1 are swallowed without touching memory
  assign slave.w_ready  = state == WRITE && slave.w_valid && (mem_gnt_i || !in_range);
  assign slave.b_valid  = state == WRITE_RESP;
  assign slave.b_id     = id_q;
  assign slave.b_resp   = {resp_err_q, 1'b0};
  assign slave.r_valid  = state == READ_DATA && r_full_q;
  assign slave.r_id     = id_q;
  assign slave.r_data   = r_buf_q;
  assign slave.r_resp   = 2'b00;
  assign slave.r_last   = cnt_q == {1'b0, len_q};
  assign mem_req_o   = state == WRITE ? slave.w_valid && in_range : state == READ_REQ;
  assign mem_we_o    = state == WRITE;
  assign mem_be_o    = state == WRITE ? slave.w_strb : 4'hF;
  assign mem_addr_o  = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = slave.w_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio_q     <= 1'b0;
      resp_err_q <= 1'b0;
      r_full_q   <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      r_buf_q    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_w || pick_r) begin
          id_q    <= pick_w ? slave.aw_id : slave.ar_id;
          addr_q  <= pick_w ? slave.aw_addr : slave.ar_addr;
          len_q   <= pick_w ? slave.aw_len : slave.ar_len;
          burst_q <= pick_w ? slave.aw_burst : slave.ar_burst;
          cnt_q   <= '0;
          state   <= pick_w ? WRITE : READ_REQ;
        end
        WRITE: if (w_hs) begin
          addr_q <= next_addr;
          cnt_q  <= cnt_q == 9'h1FF ? cnt_q : cnt_q + 9'd1;
          if (slave.w_last) begin
            resp_err_q <= cnt_q != {1'b0, len_q};
            state      <= WRITE_RESP;
          end
        end
        WRITE_RESP: if (slave.b_ready) begin
          prio_q <= 1'b1;
          state  <= IDLE;
        end
        READ_REQ: if (mem_gnt_i) state <= READ_DATA;
        READ_DATA: if (r_hs) begin
          r_full_q <= 1'b0;
          if (slave.r_last) begin
            prio_q <= 1'b0;
            state  <= IDLE;
          end else begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 9'd1;
            state  <= READ_REQ;
          end
        end else if (mem_rvalid_i && !r_full_q) begin
          r_buf_q  <= mem_rdata_i;
          r_full_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi2mem.sv
// tb_axi2mem: randomized transaction-level check of axi2mem against a memory/priority model
module tb_axi2mem;
  logic        clk, rst;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();
  axi2mem #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .slave(bus), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );
  typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  wr_t         wlog[$], wexp[$];
  logic [31:0] rlog[$];
  int          n_vec = 0, n_err = 0;
  bit          p = 0, gnt_rand = 0, rv_pend = 0, fix_wd = 0;
  logic [31:0] rv_a, fix_d;
  logic [3:0]  fix_s;
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  function automatic logic [31:0] fn(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic sig(int w);
    return w == 0 ? bus.aw_ready : w == 1 ? bus.ar_ready : w == 2 ? bus.w_ready :
           w == 3 ? bus.b_valid : bus.r_valid;
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_sig(int w, string tag);
    int t = 0;
    @(negedge clk);
    while (!sig(w) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, sig(w), 1);
  endtask
  // memory: random grant, read data one cycle after grant, every granted access logged
  initial begin
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    forever begin
      step;
      mem_rvalid_i = rv_pend;
      mem_rdata_i  = rv_pend ? fn(rv_a) : $urandom;
      rv_pend      = 0;
      mem_gnt_i    = gnt_rand ? ($urandom % 3 != 0) : 1'b1;
      @(negedge clk);
      if (mem_req_o && mem_gnt_i && !rst) begin
        if (mem_we_o) wlog.push_back('{mem_addr_o, mem_be_o, mem_wdata_o});
        else begin
          rlog.push_back(mem_addr_o);
          rv_pend = 1;
          rv_a = mem_addr_o;
        end
      end
    end
  end
  task automatic do_write(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] burst, int n, bit aw_done);
    logic [31:0] d;
    logic [3:0]  s;
    if (!aw_done) begin
      wlog.delete(); rlog.delete();
      bus.aw_id = id; bus.aw_addr = a; bus.aw_len = len; bus.aw_burst = burst; bus.aw_valid = 1;
      wait_sig(0, "aw_rdy");
      step;
      bus.aw_valid = 0;
    end
    wexp.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom % 4 == 0) begin
        bus.w_valid = 0;
        step;
      end
      d = (fix_wd && i == 0) ? fix_d : $urandom;
      s = (fix_wd && i == 0) ? fix_s : 4'($urandom);
      bus.w_valid = 1; bus.w_data = d; bus.w_strb = s; bus.w_last = (i == n - 1);
      if (i <= int'(len)) wexp.push_back('{(burst == 2'b00 ? a : a + 32'(4 * i)) & ~32'h3, s, d});
      wait_sig(2, "w_rdy");
      step;
    end
    bus.w_valid = 0; bus.w_last = 0; bus.b_ready = 0;
    wait_sig(3, "b_vld");
    repeat ($urandom % 3) begin
      step;
      @(negedge clk);
      chk("b_hold", bus.b_valid, 1);
    end
    step;
    bus.b_ready = 1;
    @(negedge clk);
    chk("b_id", {bus.b_valid, bus.b_id}, {1'b1, id});
    chk("b_resp", bus.b_resp, n == int'(len) + 1 ? 2'b00 : 2'b10);
    step;
    bus.b_ready = 0;
    chk("wr_cnt", wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++) begin
      chk("wr_addr", wlog[i].a, wexp[i].a);
      chk("wr_be_data", {wlog[i].be, wlog[i].d}, {wexp[i].be, wexp[i].d});
    end
    p = 1;
  endtask
  task automatic do_read(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [1:0] burst, bit ar_done);
    logic [31:0] ea, d0;
    if (!ar_done) begin
      wlog.delete(); rlog.delete();
      bus.ar_id = id; bus.ar_addr = a; bus.ar_len = len; bus.ar_burst = burst; bus.ar_valid = 1;
      wait_sig(1, "ar_rdy");
      step;
      bus.ar_valid = 0;
    end
    for (int i = 0; i <= int'(len); i++) begin
      ea = (burst == 2'b00 ? a : a + 32'(4 * i)) & ~32'h3;
      wait_sig(4, "r_vld");
      d0 = bus.r_data;
      repeat ($urandom % 3) begin
        step;
        @(negedge clk);
        chk("r_hold", {bus.r_valid, bus.r_data}, {1'b1, d0});
      end
      step;
      bus.r_ready = 1;
      @(negedge clk);
      chk("r_addr", rlog.size() > i ? rlog[i] : 32'hDEAD_BEEF, ea);
      chk("r_data", bus.r_data, fn(ea));
      chk("r_last_id_resp", {bus.r_last, bus.r_id, bus.r_resp}, {i == int'(len), id, 2'b00});
      step;
      bus.r_ready = 0;
    end
    chk("rd_cnt", rlog.size(), int'(len) + 1);
    p = 0;
  endtask
  task automatic collide(logic [3:0] wid, logic [31:0] wa, logic [7:0] wlen, logic [1:0] wb, int wn,
                         logic [3:0] rid, logic [31:0] ra, logic [7:0] rlen, logic [1:0] rb);
    int t = 0;
    bit w;
    wlog.delete(); rlog.delete();
    bus.aw_id = wid; bus.aw_addr = wa; bus.aw_len = wlen; bus.aw_burst = wb; bus.aw_valid = 1;
    bus.ar_id = rid; bus.ar_addr = ra; bus.ar_len = rlen; bus.ar_burst = rb; bus.ar_valid = 1;
    @(negedge clk);
    while (!bus.aw_ready && !bus.ar_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("col_pick", {bus.aw_ready, bus.ar_ready}, p ? 2'b01 : 2'b10);
    w = bus.aw_ready;
    step;
    bus.aw_valid = 0; bus.ar_valid = 0;
    if (w) do_write(wid, wa, wlen, wb, wn, 1);
    else do_read(rid, ra, rlen, rb, 1);
  endtask
  initial begin
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] a;
    int          n;
    rst = 1;
    bus.w_valid = 0; bus.w_last = 0; bus.w_data = 0; bus.w_strb = 0; bus.b_ready = 0; bus.r_ready = 0;
    bus.aw_valid = 1; bus.aw_id = 4'h5; bus.aw_addr = 32'h100; bus.aw_len = 0; bus.aw_burst = 2'b01;
    bus.ar_valid = 1; bus.ar_id = 4'h3; bus.ar_addr = 32'h1FC; bus.ar_len = 3; bus.ar_burst = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_outs", {bus.aw_ready, bus.ar_ready, bus.b_valid, bus.r_valid, mem_req_o}, 5'b0);
    step;
    rst = 0;
    fix_wd = 1; fix_d = 32'hA5A5_1234; fix_s = 4'h3;
    collide(4'h5, 32'h100, 0, 2'b01, 1, 4'h3, 32'h1FC, 3, 2'b01);
    fix_wd = 0;
    gnt_rand = 1;
    step;
    collide(4'h9, 32'h300, 0, 2'b01, 1, 4'h3, 32'h1FC, 3, 2'b01);
    do_write(4'h2, 32'h40, 1, 2'b01, 1, 0);
    do_write(4'h4, 32'h80, 1, 2'b01, 4, 0);
    do_write(4'h6, 32'hFFFF_FFFC, 2, 2'b00, 3, 0);
    do_write(4'h7, 32'hFFFF_FFFC, 2, 2'b01, 3, 0);
    wlog.delete(); rlog.delete();
    bus.ar_id = 4'hA; bus.ar_addr = 32'h500; bus.ar_len = 2; bus.ar_burst = 2'b01; bus.ar_valid = 1;
    wait_sig(1, "ar_rdy_rst");
    step;
    bus.ar_valid = 0;
    wait_sig(4, "r_vld_rst");
    #1 rst = 1;
    #1 chk("rst_mid", {bus.r_valid, mem_req_o, bus.b_valid}, 3'b0);
    step;
    step;
    rst = 0;
    p = 0;
    chk("rst_nomem", rlog.size(), 1);
    do_read(4'hB, 32'h600, 1, 2'b01, 0);
    for (int it = 0; it < 25; it++) begin
      gnt_rand = $urandom % 2;
      len = 8'($urandom % 6);
      burst = 2'($urandom % 3);
      a = $urandom;
      n = int'(len) + 1;
      if ($urandom % 4 == 0) n = 1 + int'($urandom % (int'(len) + 3));
      case ($urandom % 3)
        0: do_write(4'($urandom), a, len, burst, n, 0);
        1: do_read(4'($urandom), a, len, burst, 0);
        default: collide(4'($urandom), a, len, burst, n, 4'($urandom), $urandom, 8'($urandom % 5), 2'($urandom % 3));
      endcase
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi2mem.md
AXI2MEM -- requirements
Module: axi2mem

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, width of AXI and memory addresses.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, width of stored transaction ID.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port slave  AXI_BUS.Slave  32-bit data  AXI4 slave port fed by the core-side AXI master.
REQ-006 SHALL have port mem_req_o  output  1  memory request.
REQ-007 SHALL have port mem_gnt_i  input  1  memory grant; request accepted this cycle.
REQ-008 SHALL have port mem_we_o  output  1  1 = write, 0 = read.
REQ-009 SHALL have port mem_be_o  output  4  byte enables.
REQ-010 SHALL have port mem_addr_o  output  AXI_ADDR_WIDTH  word-aligned address, bits[1:0] = 0.
REQ-011 SHALL have port mem_wdata_o  output  32  write data.
REQ-012 SHALL have port mem_rvalid_i  input  1  read data valid; exactly one cycle after the read grant.
REQ-013 SHALL have port mem_rdata_i  input  32  read data.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, WRITE_RESP, READ_REQ, READ_DATA.
REQ-015 IDLE SHALL accept AW (aw_ready=1 same cycle) or AR (ar_ready=1 same cycle), never both; latch id, addr, len, burst.
REQ-016 If aw_valid and ar_valid coincide, SHALL serve the direction given by prio_q (0 = write); prio_q flips after each completed transaction of the favoured direction.
REQ-017 AW accepted -> WRITE; AR accepted -> READ_REQ.
REQ-018 WRITE: mem_req_o = w_valid, mem_we_o = 1, mem_be_o = w_strb, mem_wdata_o = w_data; w_ready = w_valid & mem_gnt_i.
REQ-019 Each W handshake SHALL advance the address by 4 (INCR, WRAP) or hold it (FIXED), and increment a beat counter.
REQ-020 Address arithmetic SHALL be modulo 2^AXI_ADDR_WIDTH; wrap-around is silent.
REQ-021 W handshake with w_last -> WRITE_RESP; b_resp = OKAY (2'b00) if the beat count equals len+1, else SLVERR (2'b10).
REQ-022 Beats beyond len+1 without w_last SHALL NOT be written to memory (mem_req_o=0); they are still acknowledged (w_ready=w_valid) and the response is SLVERR.
REQ-023 WRITE_RESP: b_valid=1, b_id = latched id; hold until b_ready -> IDLE.
REQ-024 READ_REQ: mem_req_o=1, mem_we_o=0, mem_be_o=4'hF; on mem_gnt_i -> READ_DATA.
REQ-025 READ_DATA: capture mem_rdata_i on mem_rvalid_i into an r buffer; r_valid=1 from the next cycle until r_ready.
REQ-026 r_id = latched id, r_resp = OKAY, r_last = 1 when the beat counter equals len.
REQ-027 On r handshake: if r_last -> IDLE, else advance the address per REQ-019 -> READ_REQ.
REQ-028 r_data and r_valid SHALL be stable while r_valid=1 and r_ready=0; b_valid likewise.
REQ-029 No new AW/AR SHALL be accepted outside IDLE; aw_ready and ar_ready = 0 elsewhere.
REQ-030 Read latency, AR accept to first r_valid: 3 cycles minimum with gnt same cycle; single outstanding memory access.

Reset
REQ-031 rst high SHALL force IDLE and prio_q=0 and clear counters/latches asynchronously.
REQ-032 During reset: all ready/valid outputs and mem_req_o = 0.
REQ-033 Reset mid-burst SHALL abandon the transaction with no further memory access or response.
REQ-034 First cycle after rst deasserts: IDLE; AW/AR acceptance is allowed.

Verification
REQ-035 Single write, addr 0x100, strb 4'h3, data 0xA5A5_1234, gnt immediate -> mem write at 0x100 with be 4'h3; b_resp 00; b_id = aw_id.
REQ-036 INCR read, len 3, addr 0x1FC, random gnt/r_ready stalls -> mem addrs 0x1FC, 0x200, 0x204, 0x208; 4 beats in order; r_last on beat 4 only.
REQ-037 AW and AR same cycle, twice after reset -> first write served, then read; prio_q alternates.
REQ-038 Write, len 1, w_last on beat 1 -> one mem write; b_resp 2'b10.
REQ-039 FIXED write, len 2, addr 0xFFFF_FFFC -> 3 writes to 0xFFFF_FFFC; an INCR variant wraps to 0x0.
REQ-040 rst asserted in READ_DATA before r_ready -> r_valid and mem_req_o drop immediately; next AR served normally.
